// File: rtl/tone_decoder_if.sv
// Signal bundle between a tone source/monitor and tone_decoder.
// The slave side is the decoder; the master side drives the tone and reads the result.
interface tone_decoder_if #(
    parameter int unsigned CNT_W = 8
);
    logic [15:0]      ticks_per_milli;
    logic             tone_in;
    logic [2:0]       note;
    logic             note_valid;
    logic             silent;
    logic [CNT_W-1:0] freq_count;
    logic             gate_done;
    logic [7:0]       led;

    modport master (
        output ticks_per_milli,
        output tone_in,
        input  note,
        input  note_valid,
        input  silent,
        input  freq_count,
        input  gate_done,
        input  led
    );

    modport slave (
        input  ticks_per_milli,
        input  tone_in,
        output note,
        output note_valid,
        output silent,
        output freq_count,
        output gate_done,
        output led
    );
endinterface

// File: rtl/tone_decoder.sv
// Tone tuner: counts rising edges of tone_in over a 100 ms gate, bins the count to a note.
// Define TONE_DECODER_GLITCH_FILTER_EN to insert a 3-sample majority filter after the synchroniser.
module tone_decoder #(
    parameter int unsigned STABLE_GATES = 2,
    parameter int unsigned SILENCE_MAX  = 3,
    parameter int unsigned CNT_W        = 8
) (
    input logic           clk,
    input logic           rst,
    tone_decoder_if.slave bus
);
    localparam int unsigned RUN_W = $clog2(STABLE_GATES + 1) + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    typedef enum logic [1:0] {StSilent, StAcquire, StLocked, StOor} state_e;

    state_e           state_q, state_d;
    logic [RUN_W-1:0] run_q, run_d;
    logic [2:0]       note_q, note_d;
    logic [CNT_W-1:0] freq_count_q;
    logic             gate_done_q;

    logic             sync1_q, sync2_q, level, prev_q, edge_q;
    logic [15:0]      presc_q, tpm_eff;
    logic [6:0]       ms_q;
    logic             ms_tick, gate_end;
    logic [CNT_W-1:0] cnt_q;

    // Input path: synchroniser, optional majority filter, registered rising-edge detect.
`ifdef TONE_DECODER_GLITCH_FILTER_EN
    logic hist1_q, hist2_q, filt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            hist1_q <= 1'b0;
            hist2_q <= 1'b0;
            filt_q  <= 1'b0;
        end else begin
            hist1_q <= sync2_q;
            hist2_q <= hist1_q;
            filt_q  <= (sync2_q & hist1_q) | (sync2_q & hist2_q) | (hist1_q & hist2_q);
        end
    end

    assign level = filt_q;
`else
    assign level = sync2_q;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
            edge_q  <= 1'b0;
        end else begin
            sync1_q <= bus.tone_in;
            sync2_q <= sync1_q;
            prev_q  <= level;
            edge_q  <= level & ~prev_q;
        end
    end

    // Millisecond prescaler; >= lets a lowered ticks_per_milli end the ms immediately.
    assign tpm_eff  = (bus.ticks_per_milli == 16'd0) ? 16'd1 : bus.ticks_per_milli;
    assign ms_tick  = (presc_q >= tpm_eff - 16'd1);
    assign gate_end = ms_tick && (ms_q == 7'd99);

    always_ff @(posedge clk) begin
        if (rst) begin
            presc_q <= '0;
            ms_q    <= '0;
            cnt_q   <= '0;
        end else begin
            presc_q <= ms_tick ? 16'd0 : presc_q + 16'd1;
            if (ms_tick) begin
                ms_q <= gate_end ? 7'd0 : ms_q + 7'd1;
            end
            // An edge arriving on the gate-end cycle belongs to the next gate.
            if (gate_end) begin
                cnt_q <= edge_q ? CNT_W'(1) : '0;
            end else if (edge_q && (cnt_q != CNT_MAX)) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

    // Note binning of the count being closed out.
    int unsigned cnt_val;
    logic        is_silence, in_bin;
    logic [2:0]  bin_idx;

    always_comb begin
        cnt_val    = 32'(cnt_q);
        is_silence = (cnt_val <= SILENCE_MAX);
        in_bin     = 1'b1;
        bin_idx    = 3'd0;
        if (cnt_val >= 24 && cnt_val <= 27)      bin_idx = 3'd0;
        else if (cnt_val >= 28 && cnt_val <= 31) bin_idx = 3'd1;
        else if (cnt_val >= 32 && cnt_val <= 33) bin_idx = 3'd2;
        else if (cnt_val >= 34 && cnt_val <= 36) bin_idx = 3'd3;
        else if (cnt_val >= 37 && cnt_val <= 41) bin_idx = 3'd4;
        else if (cnt_val >= 42 && cnt_val <= 46) bin_idx = 3'd5;
        else if (cnt_val >= 47 && cnt_val <= 50) bin_idx = 3'd6;
        else if (cnt_val >= 51 && cnt_val <= 56) bin_idx = 3'd7;
        else                                     in_bin  = 1'b0;
    end

    always_comb begin
        state_d = state_q;
        run_d   = run_q;
        note_d  = note_q;
        if (gate_end) begin
            if (is_silence) begin
                state_d = StSilent;
                run_d   = '0;
            end else if (!in_bin) begin
                state_d = StOor;
                run_d   = '0;
            end else begin
                note_d = bin_idx;
                if ((state_q == StAcquire) && (bin_idx == note_q)) begin
                    run_d = run_q + RUN_W'(1);
                    if (32'(run_d) >= STABLE_GATES) begin
                        state_d = StLocked;
                    end
                end else if (!((state_q == StLocked) && (bin_idx == note_q))) begin
                    run_d   = RUN_W'(1);
                    state_d = (STABLE_GATES <= 1) ? StLocked : StAcquire;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StSilent;
            run_q        <= '0;
            note_q       <= 3'd0;
            freq_count_q <= '0;
            gate_done_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            run_q       <= run_d;
            note_q      <= note_d;
            gate_done_q <= gate_end;
            if (gate_end) begin
                freq_count_q <= cnt_q;
            end
        end
    end

    // Flags and LED decode straight from registered state, so they change with gate_done.
    always_comb begin
        bus.led = 8'h00;
        unique case (state_q)
            StSilent:  bus.led = 8'h00;
            StAcquire: bus.led = 8'h40;
            StOor:     bus.led = 8'h40;
            StLocked: begin
                case (note_q)
                    3'd0:    bus.led = 8'h39;
                    3'd1:    bus.led = 8'h5E;
                    3'd2:    bus.led = 8'h79;
                    3'd3:    bus.led = 8'h71;
                    3'd4:    bus.led = 8'h3D;
                    3'd5:    bus.led = 8'h77;
                    3'd6:    bus.led = 8'h7C;
                    default: bus.led = 8'hB9;
                endcase
            end
            default:   bus.led = 8'h00;
        endcase
    end

    assign bus.note       = note_q;
    assign bus.note_valid = (state_q == StLocked);
    assign bus.silent     = (state_q == StSilent);
    assign bus.freq_count = freq_count_q;
    assign bus.gate_done  = gate_done_q;
endmodule
